// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: reusable inter-stage pipeline register with valid/ready handshake,
// synchronous flush and an optional one-entry skid buffer.
//
// Parameters
//   DATA_W        payload width in bits
//   SKID          1: main+skid storage with registered in_ready; 0: single register
//   ZERO_ON_FLUSH 1: storage data cleared when emptied by flush or pop; 0: data held
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-high reset
//   flush      synchronous kill; drops every held and incoming beat
//   in_valid   upstream beat present
//   in_ready   block can take a beat this cycle
//   in_data    upstream payload
//   out_valid  downstream beat present
//   out_ready  downstream takes the beat this cycle
//   out_data   oldest held beat
//   occupancy  number of beats held (0..2)
module pipe_stage_buf #(
  parameter int unsigned DATA_W        = 160,
  parameter int unsigned SKID          = 1,
  parameter int unsigned ZERO_ON_FLUSH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  localparam bit Zero = (ZERO_ON_FLUSH != 0);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  logic main_valid;
  logic skid_valid;
  logic push;
  logic pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = main_valid;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  if (SKID != 0) begin : g_skid
    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    // in_ready comes straight from a flop so out_ready never reaches it combinationally.
    logic              ready_q;

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= StEmpty;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != StTwo);
      end
    end

    // Next-state logic.
    always_comb begin
      state_d = state_q;
      if (flush) begin
        state_d = StEmpty;
      end else begin
        unique case (state_q)
          StEmpty: if (push) state_d = StOne;
          StOne: begin
            if (push && !pop)      state_d = StTwo;
            else if (!push && pop) state_d = StEmpty;
          end
          StTwo:   if (pop) state_d = StOne;
          default: state_d = StEmpty;
        endcase
      end
    end

    // Storage update: main always holds the oldest beat, skid the younger one.
    always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (flush) begin
        if (Zero) begin
          main_d = '0;
          skid_d = '0;
        end
      end else begin
        unique case (state_q)
          StEmpty: if (push) main_d = in_data;
          StOne: begin
            if (push && pop) begin
              main_d = in_data;
            end else if (push) begin
              skid_d = in_data;
            end else if (pop && Zero) begin
              main_d = '0;
            end
          end
          StTwo: begin
            if (pop) begin
              main_d = skid_q;
              if (Zero) skid_d = '0;
            end
          end
          default: ;
        endcase
      end
    end

    // Outputs.
    always_comb begin
      main_valid = (state_q != StEmpty);
      skid_valid = (state_q == StTwo);
      in_ready   = ready_q;
      out_data   = main_q;
    end
  end else begin : g_flat
    logic [DATA_W-1:0] main_q, main_d;
    logic              valid_q, valid_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        main_q  <= '0;
      end else begin
        valid_q <= valid_d;
        main_q  <= main_d;
      end
    end

    // A push while popping refills main in the same cycle.
    always_comb begin
      valid_d = valid_q;
      main_d  = main_q;
      if (flush) begin
        valid_d = 1'b0;
        if (Zero) main_d = '0;
      end else if (push) begin
        valid_d = 1'b1;
        main_d  = in_data;
      end else if (pop) begin
        valid_d = 1'b0;
        if (Zero) main_d = '0;
      end
    end

    always_comb begin
      main_valid = valid_q;
      skid_valid = 1'b0;
      in_ready   = ~valid_q | out_ready;
      out_data   = main_q;
    end
  end

endmodule
